// File: rtl/mux_nto1_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mux_nto1_reg : N-to-1 valid/ready mux with a one-entry registered output.  |
// | Channel choice: explicit sel, or round-robin when MUX_RR_ARB_EN is defined. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mux_nto1_reg #(
  parameter int WIDTH  = 128,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam logic [SEL_W:0] C_NUM_IN = (SEL_W+1)'(NUM_IN);

  logic [SEL_W-1:0] w_chosen;
  logic             w_chosen_ok;
  logic             w_can_load;
  logic             w_xfer;
  logic [WIDTH-1:0] w_chosen_data;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_src_q,   out_src_d;

  assign w_can_load = !out_valid_q || out_ready;

`ifdef MUX_RR_ARB_EN
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W:0]   w_rr_idx;
  logic             w_rr_found;
  logic             unused_sel;

  assign unused_sel  = ^sel;
  assign w_chosen_ok = 1'b1;

  // First valid channel scanning upward from ptr; ptr itself when none is valid.
  always_comb begin
    w_chosen   = ptr_q;
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      w_rr_idx = {1'b0, ptr_q} + (SEL_W+1)'(k);
      if (w_rr_idx >= C_NUM_IN) w_rr_idx = w_rr_idx - C_NUM_IN;
      if (!w_rr_found && in_valid[w_rr_idx[SEL_W-1:0]]) begin
        w_rr_found = 1'b1;
        w_chosen   = w_rr_idx[SEL_W-1:0];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (w_xfer) ptr_d = (w_chosen == SEL_W'(NUM_IN-1)) ? '0 : w_chosen + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  assign w_chosen    = sel;
  assign w_chosen_ok = ({1'b0, sel} < C_NUM_IN);
`endif

  always_comb begin
    w_chosen_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (w_chosen == SEL_W'(i)) w_chosen_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // in_ready never looks at in_valid of its own channel in explicit mode.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_ready[i] = rst_n && w_chosen_ok && w_can_load && (w_chosen == SEL_W'(i));
    end
  end

  assign w_xfer = |(in_valid & in_ready);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (w_xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = w_chosen_data;
      out_src_d   = w_chosen;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_nto1_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mux_nto1_reg : directed self-checking bench for mux_nto1_reg.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mux_nto1_reg;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [4*W-1:0] in_data;
  logic [3:0]     in_valid, in_ready;
  logic [1:0]     sel, out_src;
  logic [W-1:0]   out_data;
  logic           out_valid, out_ready;

  logic [3*W-1:0] in_data3;
  logic [2:0]     in_valid3, in_ready3;
  logic [1:0]     sel3, out_src3;
  logic [W-1:0]   out_data3;
  logic           out_valid3, out_ready3;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  mux_nto1_reg #(.WIDTH(W), .NUM_IN(4), .SEL_W(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .out_data(out_data), .out_src(out_src),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_nto1_reg #(.WIDTH(W), .NUM_IN(3), .SEL_W(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .sel(sel3), .out_data(out_data3), .out_src(out_src3),
    .out_valid(out_valid3), .out_ready(out_ready3)
  );

  task automatic chk_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [W-1:0] v);
    in_data[ch*W +: W] = v;
  endtask

  initial begin
    logic [W-1:0] q_data[$];
    logic [1:0]   q_src[$];
    logic [W-1:0] exp_d;
    logic [1:0]   exp_s;
    int           words;
    int           e;

    rst_n = 1'b0;
    in_data = '0; in_valid = 4'hf; sel = 2'd0; out_ready = 1'b1;
    in_data3 = '0; in_valid3 = 3'b111; sel3 = 2'd0; out_ready3 = 1'b1;
    tick(); tick();
    chk_value("rst_out_valid", out_valid, 1'b0);
    chk_value("rst_out_data", out_data, 8'h00);
    chk_value("rst_out_src", out_src, 2'd0);
    chk_value("rst_in_ready", in_ready, 4'b0000);
    chk_value("rst_in_ready3", in_ready3, 3'b000);

    // Single transfer from channel 2
    rst_n = 1'b1; in_valid3 = 3'b000;
    sel = 2'd2; in_valid = 4'b0100; set_ch(2, 8'hA5);
    #1;
    chk_value("x1_in_ready", in_ready, 4'b0100);
    tick();
    chk_value("x1_out_data", out_data, 8'hA5);
    chk_value("x1_out_src", out_src, 2'd2);
    chk_value("x1_out_valid", out_valid, 1'b1);

    // Drain without new transfer keeps data
    in_valid = 4'b0000;
    tick();
    chk_value("drain_valid", out_valid, 1'b0);
    chk_value("drain_data_held", out_data, 8'hA5);

    // Stall: hold 0x11 from channel 1 under backpressure
    sel = 2'd1; in_valid = 4'b0010; set_ch(1, 8'h11);
    tick();
    chk_value("stall_load", out_data, 8'h11);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      sel = 2'(c); in_valid = 4'hf; set_ch(c, 8'hE0 + 8'(c)); set_ch(1, 8'h90 + 8'(c));
      #1;
      chk_value("stall_in_ready", in_ready, 4'b0000);
      tick();
      chk_value("stall_data", out_data, 8'h11);
      chk_value("stall_src", out_src, 2'd1);
      chk_value("stall_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1; sel = 2'd3; in_valid = 4'b1000; set_ch(3, 8'h77);
    #1;
    chk_value("unstall_in_ready", in_ready, 4'b1000);
    tick();
    chk_value("unstall_data", out_data, 8'h77);
    chk_value("unstall_src", out_src, 2'd3);

    // Reset mid-stream while holding a word
    out_ready = 1'b0; in_valid = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    chk_value("mrst_valid", out_valid, 1'b0);
    chk_value("mrst_data", out_data, 8'h00);
    chk_value("mrst_in_ready", in_ready, 4'b0000);
    tick();
    rst_n = 1'b1; sel = 2'd1; in_valid = 4'b0010; set_ch(1, 8'h3C); out_ready = 1'b1;
    #1;
    chk_value("mrst_rel_in_ready", in_ready, 4'b0010);
    tick();
    chk_value("mrst_rel_src", out_src, 2'd1);
    chk_value("mrst_rel_data", out_data, 8'h3C);
    chk_value("mrst_rel_valid", out_valid, 1'b1);

`ifdef MUX_RR_ARB_EN
    // Fresh pointer, then round-robin over all-valid channels
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    in_valid = 4'hf;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk_value("rr_seq_src", out_src, 2'(c % 4));
    end
    in_valid = 4'b0001;
    tick();
    chk_value("rr_ch0_src", out_src, 2'd0);
    in_valid = 4'b1000; set_ch(3, 8'hC3);
    #1;
    chk_value("rr_ch3_in_ready", in_ready, 4'b1000);
    tick();
    chk_value("rr_ch3_src", out_src, 2'd3);
    chk_value("rr_ch3_data", out_data, 8'hC3);
    in_valid = 4'b0000;
    #1;
    chk_value("rr_ptr_wrap_ready", in_ready, 4'b0001);
    tick();
    chk_value("rr_idle_valid", out_valid, 1'b0);
    // Three channels: wrap from 2 back to 0, sel ignored
    sel3 = 2'd3; in_valid3 = 3'b111;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_value("rr3_seq_src", out_src3, 2'(c % 3));
    end
    in_valid3 = 3'b000;
`else
    // Out-of-range select on 3-channel instance drains and then blocks
    sel3 = 2'd0; in_valid3 = 3'b001; in_data3[0 +: W] = 8'h5A;
    tick();
    chk_value("oor_pre_valid", out_valid3, 1'b1);
    sel3 = 2'd3; in_valid3 = 3'b111;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk_value("oor_in_ready", in_ready3, 3'b000);
      tick();
      chk_value("oor_out_valid", out_valid3, 1'b0);
    end
    chk_value("oor_data_held", out_data3, 8'h5A);
`endif

    // Throughput: 100 words with out_ready held high
    words = 0;
    out_ready = 1'b1;
    for (int c = 0; c <= 100; c++) begin
      if (c < 100) begin
        in_valid = 4'hf;
        for (int ch = 0; ch < 4; ch++) set_ch(ch, 8'($urandom_range(0, 255)));
        e = c % 4;
        sel = 2'(e);
        q_data.push_back(in_data[e*W +: W]);
        q_src.push_back(2'(e));
      end else begin
        in_valid = 4'b0000;
      end
      tick();
      if (out_valid) begin
        words++;
        if (q_data.size() == 0) begin
          chk_value("tp_extra_word", 1'b1, 1'b0);
        end else begin
          exp_d = q_data.pop_front();
          exp_s = q_src.pop_front();
          chk_value("tp_data", out_data, exp_d);
          chk_value("tp_src", out_src, exp_s);
        end
      end
    end
    chk_value("tp_count", words, 100);
    chk_value("tp_left", q_data.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
